// File: rtl/pool_max_2x2_row_if.sv
// ---------------------------------------------------------------------------
// pool_max_2x2_row_if
// Bundles the row-in / pooled-row-out signals of pool_max_2x2_row.
//   in_valid        one-cycle strobe, in_data holds a complete conv row
//   in_feature_idx  feature map that owns the incoming row
//   in_data         IN_COLS values, column 0 in the MSBs
//   out_valid       one-cycle strobe, pooled row valid
//   out_feature_idx feature map of the pooled row
//   out_row         pooled row index within the map
//   out_data        IN_COLS/2 pooled values, column 0 in the MSBs
//   map_done        pulses with the final pooled row of a map
//   seq_err         sticky row-sequence violation flag
// modport master: row producer side; modport slave: the pooling block.
// Parameters must match the ones given to pool_max_2x2_row.
// ---------------------------------------------------------------------------
interface pool_max_2x2_row_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IN_COLS    = 6,
    parameter int IN_ROWS    = 6,
    parameter int IDX_WIDTH  = 2
);
    localparam int OUT_COLS = IN_COLS / 2;
    localparam int ROW_W    = (IN_ROWS / 2 > 1) ? $clog2(IN_ROWS / 2) : 1;

    logic                           in_valid;
    logic [IDX_WIDTH-1:0]           in_feature_idx;
    logic [IN_COLS*DATA_WIDTH-1:0]  in_data;
    logic                           out_valid;
    logic [IDX_WIDTH-1:0]           out_feature_idx;
    logic [ROW_W-1:0]               out_row;
    logic [OUT_COLS*DATA_WIDTH-1:0] out_data;
    logic                           map_done;
    logic                           seq_err;

    modport master (
        output in_valid, in_feature_idx, in_data,
        input  out_valid, out_feature_idx, out_row, out_data, map_done, seq_err
    );

    modport slave (
        input  in_valid, in_feature_idx, in_data,
        output out_valid, out_feature_idx, out_row, out_data, map_done, seq_err
    );
endinterface

// File: rtl/pool_max_2x2_row.sv
// ---------------------------------------------------------------------------
// pool_max_2x2_row
// 2x2 / stride-2 max pooling over whole convolution rows. An even row is
// parked in a line buffer; the following odd row of the same feature map is
// pooled against it and one registered output row is produced a cycle later.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  pool_max_2x2_row_if.slave (row input, pooled row output, status)
// Values are IEEE-754 bit patterns compared without NaN/Inf special cases;
// +0 and -0 compare equal and ties go to the earliest operand in the order
// E[2k], E[2k+1], O[2k], O[2k+1].
// ---------------------------------------------------------------------------
module pool_max_2x2_row #(
    parameter int DATA_WIDTH = 32,
    parameter int IN_COLS    = 6,
    parameter int IN_ROWS    = 6,
    parameter int IDX_WIDTH  = 2
) (
    input logic              clk,
    input logic              rst,
    pool_max_2x2_row_if.slave bus
);
    localparam int OUT_COLS = IN_COLS / 2;
    localparam int PAIRS    = IN_ROWS / 2;
    localparam int ROW_W    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(PAIRS - 1);

    localparam logic [0:0] ST_WAIT_EVEN = 1'b0;
    localparam logic [0:0] ST_WAIT_ODD  = 1'b1;

    // True when cand is strictly greater than cur. Strictness is what makes
    // the earlier operand win ties in max4 below.
    function automatic logic beats(input logic [DATA_WIDTH-1:0] cand,
                                   input logic [DATA_WIDTH-1:0] cur);
        logic                  cand_neg;
        logic                  cur_neg;
        logic [DATA_WIDTH-2:0] cand_mag;
        logic [DATA_WIDTH-2:0] cur_mag;
        cand_neg = cand[DATA_WIDTH-1];
        cur_neg  = cur[DATA_WIDTH-1];
        cand_mag = cand[DATA_WIDTH-2:0];
        cur_mag  = cur[DATA_WIDTH-2:0];
        if (cand_mag == '0 && cur_mag == '0)
            beats = 1'b0;                    // +0 == -0
        else if (!cand_neg && !cur_neg)
            beats = cand_mag > cur_mag;
        else if (cand_neg && cur_neg)
            beats = cand_mag < cur_mag;
        else
            beats = !cand_neg;               // signs differ: positive wins
    endfunction

    function automatic logic [DATA_WIDTH-1:0] max4(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b,
                                                   input logic [DATA_WIDTH-1:0] c,
                                                   input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] w;
        w = a;
        if (beats(b, w)) w = b;
        if (beats(c, w)) w = c;
        if (beats(d, w)) w = d;
        max4 = w;
    endfunction

    logic [0:0]                     state_reg;
    logic [ROW_W-1:0]               row_cnt_reg;
    logic [IDX_WIDTH-1:0]           buf_idx_reg;
    logic [DATA_WIDTH-1:0]          line_buf_reg [IN_COLS];
    logic                           out_valid_reg;
    logic [IDX_WIDTH-1:0]           out_idx_reg;
    logic [ROW_W-1:0]               out_row_reg;
    logic [OUT_COLS*DATA_WIDTH-1:0] out_data_reg;
    logic                           map_done_reg;
    logic                           seq_err_reg;

    logic [DATA_WIDTH-1:0]          in_col   [IN_COLS];
    logic [DATA_WIDTH-1:0]          pooled   [OUT_COLS];
    logic                           idx_match;

    assign idx_match = (bus.in_feature_idx == buf_idx_reg);

    // Unpack the incoming row; column 0 sits in the MSBs.
    generate
        for (genvar gi = 0; gi < IN_COLS; gi++) begin : g_in_col
            assign in_col[gi] = bus.in_data[(IN_COLS-1-gi)*DATA_WIDTH +: DATA_WIDTH];
        end
        for (genvar gi = 0; gi < OUT_COLS; gi++) begin : g_pool
            assign pooled[gi] = max4(line_buf_reg[2*gi], line_buf_reg[2*gi+1],
                                     in_col[2*gi],       in_col[2*gi+1]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_WAIT_EVEN;
            row_cnt_reg   <= '0;
            buf_idx_reg   <= '0;
            for (int c = 0; c < IN_COLS; c++)
                line_buf_reg[c] <= '0;
            out_valid_reg <= 1'b0;
            out_idx_reg   <= '0;
            out_row_reg   <= '0;
            out_data_reg  <= '0;
            map_done_reg  <= 1'b0;
            seq_err_reg   <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            map_done_reg  <= 1'b0;
            if (bus.in_valid) begin
                if (state_reg == ST_WAIT_EVEN) begin
                    for (int c = 0; c < IN_COLS; c++)
                        line_buf_reg[c] <= in_col[c];
                    buf_idx_reg <= bus.in_feature_idx;
                    // A different map starting: pooled-row numbering restarts.
                    if (!idx_match)
                        row_cnt_reg <= '0;
                    state_reg <= ST_WAIT_ODD;
                end else if (idx_match) begin
                    out_valid_reg <= 1'b1;
                    out_idx_reg   <= buf_idx_reg;
                    out_row_reg   <= row_cnt_reg;
                    for (int c = 0; c < OUT_COLS; c++)
                        out_data_reg[(OUT_COLS-1-c)*DATA_WIDTH +: DATA_WIDTH] <= pooled[c];
                    map_done_reg  <= (row_cnt_reg == LAST_ROW);
                    row_cnt_reg   <= (row_cnt_reg == LAST_ROW) ? '0 : row_cnt_reg + 1'b1;
                    state_reg     <= ST_WAIT_EVEN;
                end else begin
                    // Odd row from the wrong map: drop the parked row and
                    // treat this one as the start of a fresh pair.
                    seq_err_reg <= 1'b1;
                    for (int c = 0; c < IN_COLS; c++)
                        line_buf_reg[c] <= in_col[c];
                    buf_idx_reg <= bus.in_feature_idx;
                    row_cnt_reg <= '0;
                end
            end
        end
    end

    assign bus.out_valid       = out_valid_reg;
    assign bus.out_feature_idx = out_idx_reg;
    assign bus.out_row         = out_row_reg;
    assign bus.out_data        = out_data_reg;
    assign bus.map_done        = map_done_reg;
    assign bus.seq_err         = seq_err_reg;

endmodule
